// File: rtl/shared_mem_rr_arbiter_pkg.sv
// Shared definitions for the four-core shared-memory round-robin arbiter.
package shared_mem_rr_arbiter_pkg;

    localparam int NCORES     = 4;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;

    // IDLE drives an empty bus; ISSUE carries exactly one transaction.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Zero-based core index: 0 is core1, 3 is core4.
    typedef logic [1:0] core_idx_t;

    // After reset the pointer sits on core4, so core1 is scanned first.
    localparam core_idx_t LAST_CORE = 2'd3;

    // Encode a one-hot (or all-zero) core vector into a core index.
    function automatic core_idx_t onehot_to_idx(input logic [NCORES-1:0] oh);
        core_idx_t idx;
        idx = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (oh[i]) begin
                idx = idx | core_idx_t'(i);
            end
        end
        return idx;
    endfunction

    // Number of set bits in a core vector (0..4).
    function automatic logic [2:0] count_cores(input logic [NCORES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NCORES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/shared_mem_rr_arbiter_pick.sv
// Rotating-priority picker: first eligible core after last_granted, wrapping.
module shared_rr_pick
    import shared_mem_rr_arbiter_pkg::*;
(
    input  logic [NCORES-1:0] eligible,
    input  core_idx_t         last_granted,
    output logic [NCORES-1:0] winner,
    output logic              valid
);

    core_idx_t idx;

    // Scan offsets 1..4 from the last winner; 2-bit arithmetic wraps core4 to core1.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path leaves it unassigned, which would infer a latch.
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NCORES; k++) begin
            idx = last_granted + core_idx_t'(k);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_rr_arbiter.sv
// Four-core shared-memory arbiter: one registered transaction per cycle,
// round-robin fairness, and saturating contention/grant statistics.
module shared_mem_rr_arbiter
    import shared_mem_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [ADDR_W-1:0] addr4,
    input  logic [DATA_W-1:0] todata1,
    input  logic [DATA_W-1:0] todata2,
    input  logic [DATA_W-1:0] todata3,
    input  logic [DATA_W-1:0] todata4,
    input  logic              rd1,
    input  logic              rd2,
    input  logic              rd3,
    input  logic              rd4,
    input  logic              wr1,
    input  logic              wr2,
    input  logic              wr3,
    input  logic              wr4,
    input  logic              sbit1,
    input  logic              sbit2,
    input  logic              sbit3,
    input  logic              sbit4,
    output logic              grant1,
    output logic              grant2,
    output logic              grant3,
    output logic              grant4,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              mem_read,
    output logic              mem_write,
    output logic              sharedAccess,
    output logic [CNT_W-1:0]  conflictCnt,
    output logic [CNT_W-1:0]  grantCnt
);

    logic [ADDR_W-1:0] addr_v [NCORES];
    logic [DATA_W-1:0] data_v [NCORES];
    logic [NCORES-1:0] rd_v, wr_v, sbit_v;

    assign addr_v[0] = addr1;
    assign addr_v[1] = addr2;
    assign addr_v[2] = addr3;
    assign addr_v[3] = addr4;
    assign data_v[0] = todata1;
    assign data_v[1] = todata2;
    assign data_v[2] = todata3;
    assign data_v[3] = todata4;
    assign rd_v      = {rd4, rd3, rd2, rd1};
    assign wr_v      = {wr4, wr3, wr2, wr1};
    assign sbit_v    = {sbit4, sbit3, sbit2, sbit1};

    arb_state_t        state_q, state_d;
    core_idx_t         last_q;
    logic [NCORES-1:0] grant_q, grant_d;
    logic [NCORES-1:0] eligible, winner;
    logic              win_valid;
    core_idx_t         win_idx;
    logic              contended;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              rd_d, wr_d;

    // A core just granted sits out one edge so it never holds the bus twice in a row.
    assign eligible  = sbit_v & (rd_v | wr_v) & ~grant_q;
    assign win_idx   = onehot_to_idx(winner);
    assign contended = (count_cores(eligible) > 3'd1);

    shared_rr_pick u_pick (
        .eligible     (eligible),
        .last_granted (last_q),
        .winner       (winner),
        .valid        (win_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next bus contents; the bus is all-zero unless a winner exists.
    always_comb begin
        state_d = IDLE;
        grant_d = '0;
        addr_d  = '0;
        data_d  = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        if (win_valid) begin
            state_d = ISSUE;
            grant_d = winner;
            addr_d  = addr_v[win_idx];
            data_d  = data_v[win_idx];
            wr_d    = wr_v[win_idx];
            rd_d    = rd_v[win_idx] & ~wr_v[win_idx];
        end
    end

    // Bus output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q   <= '0;
            addr      <= '0;
            data      <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            addr      <= addr_d;
            data      <= data_d;
            mem_read  <= rd_d;
            mem_write <= wr_d;
        end
    end

    assign sharedAccess = (state_q == ISSUE);
    assign grant1       = grant_q[0];
    assign grant2       = grant_q[1];
    assign grant3       = grant_q[2];
    assign grant4       = grant_q[3];

    // Round-robin pointer moves only on a grant and holds through idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= LAST_CORE;
        end else if (win_valid) begin
            last_q <= win_idx;
        end
    end

    // Saturating statistics: contended edges and issued transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflictCnt <= '0;
            grantCnt    <= '0;
        end else begin
            if (contended && (conflictCnt != '1)) begin
                conflictCnt <= conflictCnt + CNT_W'(1);
            end
            if (win_valid && (grantCnt != '1)) begin
                grantCnt <= grantCnt + CNT_W'(1);
            end
        end
    end

endmodule
